// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// sequencer states and the default datapath width.
package mdu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_UDIV  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_FIXUP,
    S_WB_LO,
    S_WB_HI
  } state_t;

  function automatic logic is_long(input op_t o);
    return (o == OP_UMULL) || (o == OP_SMULL);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath: 2*WIDTH accumulator stepping one shift-add (multiply)
// or one restoring shift-subtract (divide) per cycle, plus the fix-up ops.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               negate,
  input  logic               clear_q,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   operand;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] step_val;

  // Multiply: {hi,lo} holds partial product over the shrinking multiplier.
  // Divide: {remainder,quotient}; a clear top bit of sub_diff means no borrow.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    sub_diff  = rem_shift - {1'b0, operand};
    step_val  = acc;
    if (mode_div) begin
      if (!sub_diff[WIDTH])
        step_val = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        step_val = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      step_val = {add_sum, acc[WIDTH-1:1]};
    end else begin
      step_val = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      operand <= '0;
    end else if (load) begin
      if (mode_div) begin
        acc     <= {{WIDTH{1'b0}}, a};
        operand <= b;
      end else begin
        acc     <= {{WIDTH{1'b0}}, b};
        operand <= a;
      end
    end else if (step) begin
      acc <= step_val;
    end else if (negate) begin
      acc <= -acc;
    end else if (clear_q) begin
      acc[WIDTH-1:0] <= '0;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/UMULL/SMULL/UDIV sequencer: captures one request, iterates
// WIDTH steps, applies fix-up, then drives one or two register-file writes.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rd_lo,
  input  logic [3:0]       rd_hi,
  input  logic             set_flags,
  output logic             busy,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             flag_we,
  output logic [1:0]       flags_nz,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      count;
  op_t                op_q;
  logic [3:0]         rd_lo_q;
  logic [3:0]         rd_hi_q;
  logic               set_flags_q;
  logic               neg_q;
  logic               dbz_q;
  logic               hi_sel;

  op_t                op_in;
  logic               long_q;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               core_load;
  logic               core_step;
  logic               core_negate;
  logic               core_clear_q;
  logic               core_mode_div;
  logic [2*WIDTH-1:0] acc;

  assign op_in  = op_t'(op);
  assign long_q = is_long(op_q);

  // SMULL iterates on magnitudes; the sign is restored in FIXUP.
  assign a_in = (op_in == OP_SMULL && a[WIDTH-1]) ? -a : a;
  assign b_in = (op_in == OP_SMULL && b[WIDTH-1]) ? -b : b;

  assign core_load     = (state == S_IDLE) && start;
  assign core_step     = (state == S_ITER);
  assign core_negate   = (state == S_FIXUP) && (op_q == OP_SMULL) && neg_q;
  assign core_clear_q  = (state == S_FIXUP) && (op_q == OP_UDIV) && dbz_q;
  assign core_mode_div = (state == S_IDLE) ? (op_in == OP_UDIV) : (op_q == OP_UDIV);

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .step     (core_step),
    .negate   (core_negate),
    .clear_q  (core_clear_q),
    .mode_div (core_mode_div),
    .a        (a_in),
    .b        (b_in),
    .acc      (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      op_q        <= OP_MUL;
      rd_lo_q     <= '0;
      rd_hi_q     <= '0;
      set_flags_q <= 1'b0;
      neg_q       <= 1'b0;
      dbz_q       <= 1'b0;
      hi_sel      <= 1'b0;
      busy        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      done        <= 1'b0;
      flag_we     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      hi_sel      <= 1'b0;
      done        <= 1'b0;
      flag_we     <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q        <= op_in;
            rd_lo_q     <= rd_lo;
            rd_hi_q     <= rd_hi;
            set_flags_q <= set_flags;
            neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
            dbz_q       <= (b == '0);
            count       <= CW'(WIDTH - 1);
            busy        <= 1'b1;
            state       <= S_ITER;
          end
        end
        S_ITER: begin
          count <= count - CW'(1);
          if (count == '0)
            state <= S_FIXUP;
        end
        S_FIXUP: begin
          state   <= S_WB_LO;
          wr_en   <= 1'b1;
          wr_addr <= rd_lo_q;
          if (!long_q) begin
            done        <= 1'b1;
            flag_we     <= set_flags_q;
            div_by_zero <= (op_q == OP_UDIV) && dbz_q;
          end
        end
        S_WB_LO: begin
          if (long_q) begin
            state   <= S_WB_HI;
            wr_en   <= 1'b1;
            wr_addr <= rd_hi_q;
            hi_sel  <= 1'b1;
            done    <= 1'b1;
            flag_we <= set_flags_q;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_WB_HI: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and flags are read straight from the settled accumulator during WB.
  always_comb begin
    wr_data  = '0;
    flags_nz = '0;
    if (wr_en)
      wr_data = hi_sel ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    if (flag_we)
      flags_nz = long_q ? {acc[2*WIDTH-1], acc == '0}
                        : {acc[WIDTH-1], acc[WIDTH-1:0] == '0};
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed and random operations
// compared cycle-exactly against an arithmetic reference model.
module tb_mdu_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    rd_lo = '0;
  logic [3:0]    rd_hi = '0;
  logic          set_flags = 1'b0;
  logic          busy;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          flag_we;
  logic [1:0]    flags_nz;
  logic          done;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .rd_lo       (rd_lo),
    .rd_hi       (rd_hi),
    .set_flags   (set_flags),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flag_we     (flag_we),
    .flags_nz    (flags_nz),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // {busy, wr_en, wr_addr, wr_data, done, flag_we, flags_nz, div_by_zero}
  function automatic logic [42:0] pack_obs(input logic keep_flags);
    return {busy, wr_en, wr_addr, wr_data, done, flag_we,
            keep_flags ? flags_nz : 2'b00, div_by_zero};
  endfunction

  // Architectural result of each operation, straight from arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] lo32;
    case (o)
      2'd0: begin lo32 = x * y; return {32'h0, lo32}; end
      2'd1: return {32'h0, x} * {32'h0, y};
      2'd2: return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      default: begin
        if (y == 32'h0) return 64'h0;
        lo32 = x / y;
        return {32'h0, lo32};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] lo, input logic [3:0] hi, input logic sf,
                        input int poke_cycle);
    logic [63:0] res;
    logic        lng;
    logic        n;
    logic        z;
    logic        fl;
    logic [42:0] exp_v;
    logic [42:0] obs;
    int          bad;
    int          err0;
    err0 = errors;
    res  = model(o, x, y);
    lng  = (o == 2'd1) || (o == 2'd2);
    n    = lng ? res[63] : res[31];
    z    = lng ? (res == 64'h0) : (res[31:0] == 32'h0);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_lo = lo; rd_hi = hi; set_flags = sf;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (c == poke_cycle) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
        rd_lo = ~lo; rd_hi = ~hi; set_flags = ~sf;
      end else begin
        start = 1'b0;
      end
      if (!(busy === 1'b1 && wr_en === 1'b0 && done === 1'b0)) bad++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL iter_phase: %0d bad cycles, required 0", bad);
    end
    fl    = !lng && sf;
    exp_v = {1'b1, 1'b1, lo, res[31:0], !lng, fl, fl ? {n, z} : 2'b00,
             (o == 2'd3) && (y == 32'h0)};
    obs   = pack_obs(fl);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wb_lo: got %h required %h", obs, exp_v);
    end
    if (lng) begin
      @(posedge clk); #1;
      exp_v = {1'b1, 1'b1, hi, res[63:32], 1'b1, sf, sf ? {n, z} : 2'b00, 1'b0};
      obs   = pack_obs(sf);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL wb_hi: got %h required %h", obs, exp_v);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: busy=%b wr_en=%b done=%b required 0 0 0", busy, wr_en, done);
    end
    $display("op=%0d a=%h b=%h rd=%0d/%0d sf=%b -> %h %s", o, x, y, lo, hi, sf, res,
             (errors == err0) ? "ok" : "bad");
  endtask

  task automatic test_reset();
    checks++;
    if (pack_obs(1'b1) !== 43'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", pack_obs(1'b1));
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(2'd0, 32'd7, 32'd6, 4'd3, 4'd0, 1'b1, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 4'd5, 1'b0, 0);
    run_op(2'd2, 32'hFFFF_FFFE, 32'd3, 4'd1, 4'd2, 1'b1, 0);
    run_op(2'd2, 32'd0, 32'hFFFF_FFFB, 4'd6, 4'd7, 1'b1, 0);
    run_op(2'd3, 32'd100, 32'd7, 4'd8, 4'd0, 1'b1, 0);
    run_op(2'd3, 32'd5, 32'd0, 4'd9, 4'd0, 1'b1, 0);
    run_op(2'd2, 32'h8000_0000, 32'h8000_0000, 4'd10, 4'd10, 1'b1, 0);
  endtask

  task automatic test_start_ignored();
    int extra;
    run_op(2'd0, 32'h0001_2345, 32'h0000_0055, 4'd2, 4'd0, 1'b1, 10);
    extra = 0;
    repeat (40) begin
      if (wr_en !== 1'b0 || busy !== 1'b0) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL no_queue: %0d active cycles after op, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [4];
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  lo;
    pool[0] = 32'h0; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'h1;
    for (int i = 0; i < 30; i++) begin
      x  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      y  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(1, 31);
      lo = 4'($urandom_range(0, 15));
      run_op(2'($urandom_range(0, 3)), x, y, lo,
             ($urandom_range(0, 3) == 0) ? lo : 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 1) : 0);
    end
  endtask

  task automatic test_reset_midop();
    int bad;
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    rd_lo = 4'd4; rd_hi = 4'd5; set_flags = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pack_obs(1'b1) !== 43'h0) begin
      errors++;
      $display("FAIL reset_midop: got %h required 0", pack_obs(1'b1));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: %0d active cycles, required 0", bad);
    end
    run_op(2'd0, 32'd7, 32'd6, 4'd3, 4'd0, 1'b1, 0);
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
